// File: rtl/color_conv_inv_if.sv
// color_conv_inv_if
//   Pixel stream bundle used on both sides of color_conv_inv.
//   data : 24-bit packed pixel
//   vld  : producer has a pixel this cycle
//   rdy  : consumer takes the pixel this cycle (transfer on vld & rdy)
//   master modport drives data/vld, slave modport drives rdy.
interface color_conv_inv_if;
    logic [23:0] data;
    logic        vld;
    logic        rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/color_conv_inv.sv
// color_conv_inv
//   Full-range (JPEG/BT.601) YCbCr -> RGB888 converter, 3-stage pipeline with
//   a global stall, 1 pixel/cycle. With color_conv_en_i low the block is a
//   combinational pass-through and the pipeline valid bits are cleared.
//
//   Ports
//     clk_i           : clock, rising edge
//     rst_i           : synchronous active-high reset
//     color_conv_en_i : 1 = convert, 0 = bypass
//     pix_in          : slave stream, data = {Y,U,V}
//     pix_out         : master stream, data = {R,G,B}
//     busy_o          : some pipeline stage holds a valid pixel
//
//   Build option
//     COLOR_CONV_INV_ROUND_EN : add +128 before the >>>8 (round-half-up);
//                               undefined means plain floor.
module color_conv_inv #(
    parameter int COEF_RV = 359,   // 1.402   * 256
    parameter int COEF_GU = 88,    // 0.34414 * 256
    parameter int COEF_GV = 183,   // 0.71414 * 256
    parameter int COEF_BU = 454    // 1.772   * 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    color_conv_en_i,
    color_conv_inv_if.slave         pix_in,
    color_conv_inv_if.master        pix_out,
    output logic                    busy_o
);

    localparam int STAGES = 3;

    localparam logic signed [17:0] C_RV = 18'(COEF_RV);
    localparam logic signed [17:0] C_GU = 18'(COEF_GU);
    localparam logic signed [17:0] C_GV = 18'(COEF_GV);
    localparam logic signed [17:0] C_BU = 18'(COEF_BU);

    logic [STAGES:1] vld_pipe;
    logic            stall;
    logic            adv;

    // stage 1
    logic [7:0]        y1;
    logic signed [8:0] du, dv;
    // stage 2
    logic [15:0]        yq;
    logic signed [17:0] prv, pgu, pgv, pbu;
    logic signed [17:0] prv_n, pgu_n, pgv_n, pbu_n;
    // stage 3
    logic signed [19:0] s_r, s_g, s_b;
    logic [23:0]        rgb;

    // Shift to 8.0, then clamp into the byte range.
    function automatic logic [7:0] sat8(input logic signed [19:0] s);
        logic signed [19:0] r;
`ifdef COLOR_CONV_INV_ROUND_EN
        r = (s + 20'sd128) >>> 8;
`else
        r = s >>> 8;
`endif
        if (r < 20'sd0)
            sat8 = 8'd0;
        else if (r > 20'sd255)
            sat8 = 8'd255;
        else
            sat8 = r[7:0];
    endfunction

    // Only a stalled output can back-pressure; stages never collapse bubbles.
    assign stall = vld_pipe[STAGES] & ~pix_out.rdy;
    assign adv   = ~stall;

    assign prv_n = C_RV * 18'(dv);
    assign pgu_n = C_GU * 18'(du);
    assign pgv_n = C_GV * 18'(dv);
    assign pbu_n = C_BU * 18'(du);

    assign s_r = $signed({4'b0, yq}) + 20'(prv);
    assign s_g = $signed({4'b0, yq}) - 20'(pgu) - 20'(pgv);
    assign s_b = $signed({4'b0, yq}) + 20'(pbu);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            y1       <= '0;
            du       <= '0;
            dv       <= '0;
            yq       <= '0;
            prv      <= '0;
            pgu      <= '0;
            pgv      <= '0;
            pbu      <= '0;
            rgb      <= '0;
        end else if (!color_conv_en_i) begin
            // bypass drops anything in flight; data regs are left as they are
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_in.vld};
            y1       <= pix_in.data[23:16];
            du       <= $signed({1'b0, pix_in.data[15:8]}) - 9'sd128;
            dv       <= $signed({1'b0, pix_in.data[7:0]})  - 9'sd128;
            yq       <= {y1, 8'h00};
            prv      <= prv_n;
            pgu      <= pgu_n;
            pgv      <= pgv_n;
            pbu      <= pbu_n;
            rgb      <= {sat8(s_r), sat8(s_g), sat8(s_b)};
        end
    end

    always_comb begin
        pix_out.data = rgb;
        pix_out.vld  = vld_pipe[STAGES];
        pix_in.rdy   = adv;
        if (!color_conv_en_i) begin
            pix_out.data = pix_in.data;
            pix_out.vld  = pix_in.vld;
            pix_in.rdy   = pix_out.rdy;
        end
    end

    assign busy_o = |vld_pipe;

endmodule

// File: tb/tb_color_conv_inv.sv
module tb_color_conv_inv;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic busy;

    color_conv_inv_if pin ();
    color_conv_inv_if pout ();

    always #5 clk = ~clk;

    color_conv_inv dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .color_conv_en_i (en),
        .pix_in          (pin),
        .pix_out         (pout),
        .busy_o          (busy)
    );

    typedef struct {
        logic [23:0] d;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    bit   tog   = 1'b0;

`ifdef COLOR_CONV_INV_ROUND_EN
    localparam logic [23:0] EXP_ZERO = 24'h008800;
`else
    localparam logic [23:0] EXP_ZERO = 24'h008700;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one pixel, hold until accepted, queue the expected output.
    task automatic send(input logic [23:0] pix, input logic [23:0] exp, input bit lat);
        bit done;
        done = 1'b0;
        pin.data = pix;
        pin.vld  = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!en) check("byp_rdy", {23'd0, pin.rdy}, {23'd0, pout.rdy});
            if (pin.rdy) begin
                sb.push_back('{d: exp, cyc: cyc, lat: lat});
                n_acc++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: pixel %h never accepted", pix);
        end
        pin.vld = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && pout.vld && pout.rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out: got %h expected none", pout.data);
                end else begin
                    e = sb.pop_front();
                    check("pixel", pout.data, e.d);
                    if (e.lat) check("latency", 24'(cyc - e.cyc), 24'd3);
                end
            end
        end
    end

    // Random downstream ready for the bypass section
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) pout.rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic drain();
        for (int i = 0; i < 100 && (sb.size() != 0 || busy); i++) @(posedge clk);
        #1;
        check("drained", 24'(sb.size()), 24'd0);
    endtask

    initial begin
        logic [23:0] r;
        rst      = 1'b1;
        en       = 1'b1;
        pin.data = '0;
        pin.vld  = 1'b0;
        pout.rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld",  {23'd0, pout.vld}, 24'd0);
        check("rst_data", pout.data, 24'd0);
        check("rst_busy", {23'd0, busy}, 24'd0);
        check("rst_rdy",  {23'd0, pin.rdy}, 24'd1);
        @(posedge clk);
        #1;

        // vectors 1-4 back-to-back, full throughput, latency tracked
        send(24'h808080, 24'h808080, 1'b1);
        send(24'hFF80FF, 24'hFFA4FF, 1'b1);
        send(24'h000000, EXP_ZERO,   1'b1);
        send(24'h4C55FF, 24'hFE0000, 1'b1);
        drain();

        // back-pressure: 3 accepted, then rdy_o drops; release and drain in order
        pout.rdy = 1'b0;
        n_acc    = 0;
        fork
            begin
                send(24'h808080, 24'h808080, 1'b0);
                send(24'hFF80FF, 24'hFFA4FF, 1'b0);
                send(24'h000000, EXP_ZERO,   1'b0);
                send(24'h4C55FF, 24'hFE0000, 1'b0);
                send(24'hFF8080, 24'hFFFFFF, 1'b0);
            end
            begin
                repeat (8) @(negedge clk);
                #2;
                check("stall_acc",  24'(n_acc), 24'd3);
                check("stall_rdy",  {23'd0, pin.rdy}, 24'd0);
                check("stall_busy", {23'd0, busy}, 24'd1);
                check("stall_vld",  {23'd0, pout.vld}, 24'd1);
                @(posedge clk);
                #1;
                pout.rdy = 1'b1;
            end
        join
        drain();

        // reset while the pipeline is full
        pout.rdy = 1'b0;
        fork
            begin
                send(24'h808080, 24'h808080, 1'b0);
                send(24'h808080, 24'h808080, 1'b0);
                send(24'h808080, 24'h808080, 1'b0);
            end
        join
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_vld",  {23'd0, pout.vld}, 24'd0);
        check("mid_rst_busy", {23'd0, busy}, 24'd0);
        check("mid_rst_data", pout.data, 24'd0);
        pout.rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // bypass: random pixels, random downstream ready
        en = 1'b0;
        @(negedge clk);
        check("byp_busy", {23'd0, busy}, 24'd0);
        @(posedge clk);
        #1;
        tog = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r = 24'($urandom);
            send(r, r, 1'b0);
        end
        tog      = 1'b0;
        pout.rdy = 1'b1;
        drain();
        check("byp_busy_end", {23'd0, busy}, 24'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
